// File: rtl/axis_pkt_framer.sv
// AXI-Stream packet framer: generates tlast every cfg_pkt_len beats or on
// early end-of-data, with a registered two-entry output buffer and stats.
module axis_pkt_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  short_count
);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;

  logic                  r_s_tready;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic                  r_out_short;

  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_skid_last;
  logic                  r_skid_short;

  logic [CNT_WIDTH-1:0]  r_pkt_cnt;
  logic [CNT_WIDTH-1:0]  r_short_cnt;

  logic                  w_acc;
  logic                  w_drain;
  logic [LEN_WIDTH-1:0]  w_cfg_len;
  logic [LEN_WIDTH-1:0]  w_cnt_inc;
  logic                  w_reached;
  logic                  w_last;
  logic                  w_short;
  logic                  w_skid_nxt;

  assign w_acc     = s_tvalid & r_s_tready;
  assign w_drain   = r_out_valid & m_tready;
  assign w_cfg_len = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  assign w_cnt_inc = r_beat_cnt + LEN_WIDTH'(1);

  // In IN_PKT beat_cnt < len_q, so the increment cannot overflow.
  assign w_reached = (r_state == IDLE) ? (w_cfg_len == LEN_WIDTH'(1))
                                       : (w_cnt_inc == r_len);
  assign w_last    = w_reached | s_tlast;
  assign w_short   = s_tlast & ~w_reached;

  always_comb begin
    w_skid_nxt = r_skid_valid;
    if (w_drain) begin
      w_skid_nxt = 1'b0;
    end else if (w_acc && r_out_valid) begin
      w_skid_nxt = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else if (w_acc) begin
      unique case (r_state)
        IDLE: begin
          r_len      <= w_cfg_len;
          r_beat_cnt <= LEN_WIDTH'(1);
          r_state    <= w_last ? IDLE : IN_PKT;
        end
        IN_PKT: begin
          if (w_last) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
          end else begin
            r_beat_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_s_tready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_short  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
      r_skid_short <= 1'b0;
    end else begin
      r_s_tready   <= ~w_skid_nxt;
      r_skid_valid <= w_skid_nxt;
      if (w_drain) begin
        if (r_skid_valid) begin
          r_out_data  <= r_skid_data;
          r_out_last  <= r_skid_last;
          r_out_short <= r_skid_short;
        end else if (w_acc) begin
          r_out_data  <= s_tdata;
          r_out_last  <= w_last;
          r_out_short <= w_short;
        end else begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end else if (w_acc) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= s_tdata;
          r_out_last  <= w_last;
          r_out_short <= w_short;
        end else begin
          r_skid_data  <= s_tdata;
          r_skid_last  <= w_last;
          r_skid_short <= w_short;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_pkt_cnt   <= '0;
      r_short_cnt <= '0;
    end else if (w_drain && r_out_last) begin
      r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
      if (r_out_short) begin
        r_short_cnt <= r_short_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign s_tready    = r_s_tready;
  assign m_tdata     = r_out_data;
  assign m_tvalid    = r_out_valid;
  assign m_tlast     = r_out_last;
  assign pkt_count   = r_pkt_cnt;
  assign short_count = r_short_cnt;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Directed bench for axis_pkt_framer: vector table for framing and
// counters, hand sequences for backpressure, reset and wrap.
module tb_axis_pkt_framer;

  logic        aclk;
  logic        areset_n;
  logic [7:0]  cfg_pkt_len;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [15:0] pkt_count;
  logic [15:0] short_count;

  axis_pkt_framer #(
    .DATA_WIDTH(32),
    .LEN_WIDTH(8),
    .CNT_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .areset_n(areset_n),
    .cfg_pkt_len(cfg_pkt_len),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tlast(s_tlast),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast(m_tlast),
    .pkt_count(pkt_count),
    .short_count(short_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    int          cfg;
    logic        mv;
    logic [31:0] md;
    logic        ml;
    int          pkt;
    int          sh;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } sb_t;

  vec_t tbl[$];
  sb_t  q[$];
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input int d, input logic l,
                              input int cfg, input logic mv,
                              input logic ml, input int pkt, input int sh);
    vec_t t;
    t.v   = v;
    t.d   = 32'(d);
    t.l   = l;
    t.cfg = cfg;
    t.mv  = mv;
    t.md  = 32'(d);
    t.ml  = ml;
    t.pkt = pkt;
    t.sh  = sh;
    return t;
  endfunction

  initial begin
    vec_t t;
    sb_t  e;
    sb_t  s;
    int   nk;
    int   lastcnt;
    int   lastidx;
    logic stall_prev;
    logic [31:0] prev_d;
    logic prev_l;
    logic acc;
    logic xfer;
    logic [3:0] pat;

    total = 0;
    bad   = 0;

    // framing: len 4, len 0, short packet, tlast at length
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(1, i, 0, 4, 1, (i % 4) == 3, i / 4, 0));
    tbl.push_back(mk(0, 0, 0, 4, 0, 0, 3, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 100 + k, 0, 0, 1, 1, 3 + k, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6, 0));
    for (int n = 1; n <= 11; n++)
      tbl.push_back(mk(1, 200 + n, n == 3, 8, 1, (n == 3) || (n == 11),
                       (n <= 3) ? 6 : 7, (n <= 3) ? 0 : 1));
    tbl.push_back(mk(0, 0, 0, 8, 0, 0, 8, 1));
    for (int n = 1; n <= 2; n++)
      tbl.push_back(mk(1, 400 + n, n == 2, 2, 1, n == 2, 8, 1));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 9, 1));

    areset_n    = 1'b0;
    cfg_pkt_len = 8'd4;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    m_tready    = 1'b1;
    tick();
    tick();
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tlast", 32'(m_tlast), 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    chk("rst_short", 32'(short_count), 0);
    areset_n = 1'b1;
    tick();
    chk("rel_s_tready", 32'(s_tready), 1);
    chk("rel_m_tvalid", 32'(m_tvalid), 0);

    foreach (tbl[i]) begin
      t           = tbl[i];
      cfg_pkt_len = 8'(t.cfg);
      s_tvalid    = t.v;
      s_tdata     = t.d;
      s_tlast     = t.l;
      m_tready    = 1'b1;
      tick();
      chk($sformatf("v%0d_mvalid", i), 32'(m_tvalid), 32'(t.mv));
      if (t.mv) begin
        chk($sformatf("v%0d_mdata", i), m_tdata, t.md);
        chk($sformatf("v%0d_mlast", i), 32'(m_tlast), 32'(t.ml));
      end
      chk($sformatf("v%0d_pkt", i), 32'(pkt_count), 32'(t.pkt));
      chk($sformatf("v%0d_short", i), 32'(short_count), 32'(t.sh));
      chk($sformatf("v%0d_sready", i), 32'(s_tready), 1);
    end

    // backpressure: fill output, then skid, then release
    cfg_pkt_len = 8'd4;
    s_tlast     = 1'b0;
    m_tready    = 1'b0;
    s_tvalid    = 1'b1;
    s_tdata     = 32'd300;
    tick();
    chk("bp_out_data", m_tdata, 300);
    chk("bp_sready_1", 32'(s_tready), 1);
    s_tdata = 32'd301;
    tick();
    chk("bp_sready_drop", 32'(s_tready), 0);
    chk("bp_hold_data", m_tdata, 300);
    s_tdata  = 32'd302;
    m_tready = 1'b1;
    tick();
    chk("bp_skid_data", m_tdata, 301);
    chk("bp_skid_last", 32'(m_tlast), 0);
    chk("bp_sready_rise", 32'(s_tready), 1);

    e.d = 32'd301;
    e.l = 1'b0;
    q.push_back(e);
    nk         = 2;
    stall_prev = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    pat        = 4'b1001;
    for (int c = 0; c < 56; c++) begin
      s_tvalid = (c < 48);
      s_tdata  = 32'(300 + nk);
      m_tready = (c < 48) ? pat[3 - (c % 4)] : 1'b1;
      #0;
      if (stall_prev) begin
        chk("stall_valid", 32'(m_tvalid), 1);
        chk("stall_data", m_tdata, prev_d);
        chk("stall_last", 32'(m_tlast), 32'(prev_l));
      end
      acc  = s_tvalid & s_tready;
      xfer = m_tvalid & m_tready;
      if (xfer) begin
        if (q.size() == 0) begin
          chk("sb_extra_beat", m_tdata, 32'hffff_ffff);
        end else begin
          s = q.pop_front();
          chk("sb_data", m_tdata, s.d);
          chk("sb_last", 32'(m_tlast), 32'(s.l));
        end
      end
      if (acc) begin
        e.d = 32'(300 + nk);
        e.l = (nk % 4) == 3;
        q.push_back(e);
        nk++;
      end
      stall_prev = m_tvalid & ~m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
      tick();
    end
    chk("sb_drained", 32'(q.size()), 0);

    // reset in the middle of a packet
    cfg_pkt_len = 8'd5;
    s_tvalid    = 1'b1;
    m_tready    = 1'b1;
    s_tdata     = 32'd500;
    tick();
    s_tdata = 32'd501;
    tick();
    areset_n = 1'b0;
    s_tvalid = 1'b0;
    tick();
    chk("mr_m_tvalid", 32'(m_tvalid), 0);
    chk("mr_m_tlast", 32'(m_tlast), 0);
    chk("mr_m_tdata", m_tdata, 0);
    chk("mr_s_tready", 32'(s_tready), 0);
    chk("mr_pkt", 32'(pkt_count), 0);
    chk("mr_short", 32'(short_count), 0);
    tick();
    areset_n = 1'b1;
    tick();
    chk("mr_rel_sready", 32'(s_tready), 1);
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(10 + i);
      tick();
      chk($sformatf("mr_data%0d", i), m_tdata, 32'(10 + i));
      chk($sformatf("mr_last%0d", i), 32'(m_tlast), 32'(i == 4));
    end
    s_tvalid = 1'b0;
    tick();
    tick();
    chk("mr_pkt_after", 32'(pkt_count), 1);
    chk("mr_short_after", 32'(short_count), 0);

    // max length; cfg change mid-packet has no effect
    cfg_pkt_len = 8'd255;
    lastcnt     = 0;
    lastidx     = -1;
    for (int i = 0; i < 255; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(i);
      tick();
      if (i == 0) cfg_pkt_len = 8'd2;
      if (m_tvalid && m_tlast) begin
        lastcnt++;
        lastidx = i;
      end
    end
    s_tvalid = 1'b0;
    tick();
    tick();
    chk("max_last_count", 32'(lastcnt), 1);
    chk("max_last_index", 32'(lastidx), 254);
    chk("max_pkt", 32'(pkt_count), 2);

    // counter wrap: 65537 single-beat packets
    areset_n = 1'b0;
    tick();
    areset_n    = 1'b1;
    cfg_pkt_len = 8'd1;
    tick();
    s_tvalid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      s_tdata = 32'(i);
      tick();
    end
    s_tvalid = 1'b0;
    tick();
    tick();
    chk("wrap_pkt", 32'(pkt_count), 1);
    chk("wrap_short", 32'(short_count), 0);
    chk("wrap_idle", 32'(m_tvalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_pkt_framer.md
# axis_pkt_framer

Single-clock AXI-Stream framing stage that sits directly upstream of the AXI-Stream FIFO write port. It accepts a raw beat stream and generates `tlast`, closing a packet every `cfg_pkt_len` beats or early when the source flags end-of-data. A two-entry output buffer (output register plus skid register) gives full throughput with registered handshakes. Packet statistics counters support debug.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of `s_tdata`/`m_tdata`.
- `LEN_WIDTH`, 8: width of `cfg_pkt_len` and of the internal beat counter.
- `CNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `aclk`  in  1: clock; all logic on the rising edge.
- `areset_n`  in  1: reset, synchronous, active-low.
- `cfg_pkt_len`  in  LEN_WIDTH: beats per packet; sampled on each packet's first accepted beat; 0 is treated as 1.
- `s_tdata`  in  DATA_WIDTH: input beat data.
- `s_tvalid`  in  1: input beat valid.
- `s_tready`  out  1: input ready; registered.
- `s_tlast`  in  1: early end-of-packet request; forces `tlast` on this beat.
- `m_tdata`  out  DATA_WIDTH: output beat data; registered.
- `m_tvalid`  out  1: output valid; registered.
- `m_tready`  in  1: output ready (the FIFO's `~full`).
- `m_tlast`  out  1: generated end-of-packet; registered.
- `pkt_count`  out  CNT_WIDTH: packets completed on the output.
- `short_count`  out  CNT_WIDTH: packets closed early by `s_tlast`.

## Operation
- **Accept rules.**
  - Input accept = `s_tvalid & s_tready`.
  - Output transfer = `m_tvalid & m_tready`.
- **Framing state machine.**
  - `IDLE`: no packet open. An accepted beat latches `len_q = max(cfg_pkt_len, 1)` and sets `beat_cnt` to 1.
    - If `len_q == 1` or `s_tlast`, the beat is marked last and the state stays `IDLE`.
    - Otherwise the state goes to `IN_PKT`.
  - `IN_PKT`: each accepted beat increments `beat_cnt`.
    - The beat is marked last when `beat_cnt + 1 == len_q` or `s_tlast`; the state then returns to `IDLE` and `beat_cnt` is cleared to 0.
  - `cfg_pkt_len` changes while in `IN_PKT` have no effect until the next packet.
- **Per-beat flags.**
  - `last` and `short` are stored with the data.
  - `short = s_tlast & ~(length reached)`.
- **Buffering.**
  - An accepted beat loads the output register if it is empty or draining this cycle; otherwise it loads the skid register.
  - When the output drains and the skid register is full, the skid contents move into the output register.
  - `s_tready` next = `~skid_valid` next. It never drops combinationally.
- **Counters.**
  - Both counters update on an output transfer with `m_tlast`. `short_count` updates only if the beat's `short` flag is set.
  - Both wrap modulo 2^CNT_WIDTH.
  - Updates are visible the cycle after the transfer.
- **Integrity.**
  - Data and flags are never dropped, duplicated or reordered.
  - `m_tdata`, `m_tlast` and `m_tvalid` hold stable while `m_tvalid & ~m_tready`.

## Timing
- **Reset** (`areset_n` low at a rising edge):
  - All outputs go to 0: `s_tready=0`, `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`, both counters 0.
  - The state goes to `IDLE`, `beat_cnt=0`, and both buffers are emptied.
  - `s_tready` rises on the first edge with `areset_n` high.
- **Reset mid-packet:** in-flight beats are discarded. The next accepted beat starts a new packet.
- **Latency:** 1 cycle from input accept to `m_tvalid`, when the output register is empty.
- **Throughput:** 1 beat/cycle while `m_tready` stays high.
- **Backpressure:**
  - `m_tready` low with the output full: the next accepted beat fills the skid register and `s_tready` falls on the following edge.
  - `m_tready` high again: the skid drains and `s_tready` rises on the following edge.
- **Boundary cases:**
  - Simultaneous accept and drain with the skid register empty: the output register reloads and the skid stays empty.
  - `beat_cnt` never exceeds `len_q`, and `len_q = 2^LEN_WIDTH-1` is legal.
  - `s_tlast` on the beat that also reaches length: the packet counts as normal, not short.

## Test plan
1. `cfg_pkt_len=4`, 12 back-to-back beats `0..11`, `m_tready=1` -> `m_tlast` on data 3, 7, 11; `pkt_count=3`; `short_count=0`; no bubbles after first output.
2. `cfg_pkt_len=0`, 3 beats -> every beat carries `m_tlast`; `pkt_count=3`.
3. `cfg_pkt_len=8`, `s_tlast` on beat 3 (the 3rd beat), then 8 more beats -> `tlast` on the 3rd beat and on the 11th beat; `short_count=1`, `pkt_count=2`.
4. `cfg_pkt_len=4`, continuous input, `m_tready` toggled 1-0-0-1 pattern -> `s_tready` drops exactly one cycle after the skid fills; output sequence equals input sequence; `m_tdata`/`m_tlast` stable while stalled.
5. `cfg_pkt_len=5`, reset asserted after beat 2 and released, then 5 beats `A..E` -> outputs 0 during reset; `s_tready=1` one edge after release; `tlast` on E only; `pkt_count=1`.
6. `CNT_WIDTH=16`, counter preloaded near wrap by sending 65537 single-beat packets -> `pkt_count` reads 1.
